// File: rtl/fsm_pkg.sv
// rtl/fsm_pkg.sv - shared state encoding for the run-control FSM family
package fsm_pkg;

  localparam int STATE_W = 2;

  // Code 3 is unused; every FSM here treats it as a return to idle.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsm_cnt_run.sv
// rtl/fsm_cnt_run.sv - run-control FSM: N counted RUN cycles, done pulse, abort
module fsm_cnt_run
  import fsm_pkg::*;
#(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_run,
  input  logic [CNT_WIDTH-1:0] i_num_cnt,
  input  logic                 i_abort,
  output logic                 o_idle,
  output logic                 o_running,
  output logic [CNT_WIDTH-1:0] o_cnt,
  output logic                 o_done
);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] num_q, num_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      num_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    num_d   = num_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (i_run) begin
          num_d   = i_num_cnt;
          cnt_d   = '0;
          state_d = (i_num_cnt == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins even on the final cycle, so no done pulse follows it.
        if (i_abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == num_q - CNT_WIDTH'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    o_idle    = 1'b0;
    o_running = 1'b0;
    o_done    = 1'b0;
    o_cnt     = '0;
    case (state_q)
      S_RUN: begin
        o_running = 1'b1;
        o_cnt     = cnt_q;
      end
      S_DONE:  o_done = 1'b1;
      default: o_idle = 1'b1;
    endcase
  end

endmodule

// File: doc/fsm_cnt_run.md
Name: fsm_cnt_run

Overview:
Parameterised run-control FSM: start on i_run, execute a programmable number of RUN cycles, pulse done, return to idle. Successor to the fixed IDLE/RUN/DONE controller. Adds a loop counter of configurable width, per-cycle run index, abort, and status outputs. Used as the sequencing core for counter/datapath blocks in this directory.

Parameters:
CNT_WIDTH, 8, width of i_num_cnt, internal counter and o_cnt; max run length 2^CNT_WIDTH-1 cycles.

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  reset; asynchronous, active-low
i_run  input  1  start request, sampled only in IDLE
i_num_cnt  input  CNT_WIDTH  number of RUN cycles; latched when i_run is accepted
i_abort  input  1  synchronous abort, effective only in RUN
o_idle  output  1  high in IDLE
o_running  output  1  high in RUN
o_cnt  output  CNT_WIDTH  current run index, 0..N-1 while RUN; 0 otherwise
o_done  output  1  one-cycle pulse in DONE

Behaviour:
- States (2-bit encoding): S_IDLE=0, S_RUN=1, S_DONE=2. Code 3 is illegal and next-states to S_IDLE.
- Three always blocks: state register, combinational next-state, Moore output decode from the registered state. No output depends combinationally on inputs.
- Reset (async assert, sync to clk on release): state=S_IDLE, num_q=0, cnt_q=0. Resulting outputs: o_idle=1, o_running=0, o_done=0, o_cnt=0.
- IDLE, i_run=1, i_num_cnt=N>0:
  - Latch num_q=N and clear cnt_q=0.
  - Go to RUN next cycle.
- IDLE, i_run=1, i_num_cnt=0: go directly to DONE. No RUN cycles; o_done is high the cycle after the request.
- IDLE, i_run=0: stay in IDLE.
- RUN:
  - o_cnt=cnt_q.
  - If cnt_q==num_q-1, go to DONE and clear cnt_q.
  - Otherwise cnt_q increments by 1.
  - RUN lasts exactly N cycles. o_cnt runs 0..N-1 and never wraps.
- RUN, i_abort=1:
  - Go to IDLE next cycle and clear cnt_q. o_done is not asserted.
  - Abort has priority over completion on the final RUN cycle.
- DONE: o_done=1 for exactly one cycle, then unconditionally IDLE. i_run in DONE is ignored.
- Latency:
  - i_run sampled at edge t0 gives o_running high for cycles t0+1..t0+N.
  - o_done is high at t0+N+1; o_idle is high again at t0+N+2.
- Back-to-back: with i_run held high, a new run is accepted in the IDLE cycle after DONE. Minimum gap between runs is 1 idle cycle.
- Inputs outside their sampling state are ignored: i_run in RUN/DONE, i_num_cnt after latch, i_abort outside RUN.
- reset_n asserted mid-run: immediate return to IDLE with reset values. No o_done is generated.
- Exactly one of o_idle/o_running/o_done is high in every cycle.

Decomposition:
- Shared package fsm_pkg holds the state localparams (S_IDLE, S_RUN, S_DONE) and the state width constant (2). The older FSM blocks share the same encoding.
- No sub-module. The counter is small enough to stay inline.

Test Plan:
1. Hold reset_n=0 for 3 cycles, then release -> o_idle=1, o_running=0, o_done=0, o_cnt=0. Assert reset_n=0 asynchronously between edges -> outputs return to reset values before the next edge.
2. i_run=1, i_num_cnt=5 for one cycle at t0 -> o_running=1 at t0+1..t0+5 with o_cnt=0,1,2,3,4; o_done=1 only at t0+6; o_idle=1 at t0+7.
3. i_run=1, i_num_cnt=0 -> o_done=1 at t0+1, o_running never high, o_idle=1 at t0+2.
4. Start with N=3. During RUN, pulse i_run and change i_num_cnt to 9 -> run still lasts 3 cycles. Then hold i_run=1 continuously -> next run is accepted after exactly one o_idle cycle.
5. N=5, assert i_abort when o_cnt=2 -> o_idle=1 next cycle, o_done never pulses. Abort on the final RUN cycle (o_cnt=4) -> IDLE, no o_done.
6. CNT_WIDTH=8, N=255 -> 255 RUN cycles, o_cnt ends at 254, o_done once. Repeat with reset_n dropped at o_cnt=100 -> IDLE immediately, no o_done.
